// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the V-CORE multi-cycle sequencer: FSM states,
// opcode class constants and PC source selects.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RST    = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HLT    = 3'd6
   } state_e;

   typedef enum logic [1:0] {
      PC_SRC_SEQ    = 2'b00,
      PC_SRC_BRANCH = 2'b01,
      PC_SRC_JUMP   = 2'b10
   } pc_src_e;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_HALT   = 7'b1111111;

   // Width of the memory wait counter; it only ever holds MEM_TIMEOUT-1.
   function automatic int wait_cnt_width(input int timeout);
      return (timeout > 1) ? $clog2(timeout) : 1;
   endfunction

endpackage : cpu_ctrl_pkg

// File: rtl/cpu_seq_ctrl_if.sv
// Bundle of sequencer <-> datapath/memory signals. master = sequencer,
// slave = datapath and unified memory port.
interface cpu_seq_ctrl_if #(
   parameter int OPC_W = 7,
   parameter int CNT_W = 32
);

   logic [OPC_W-1:0] opcode;
   logic             branch_taken;
   logic             mem_ack;

   logic             mem_req;
   logic             mem_we;
   logic             mem_sel_data;
   logic             ir_load;
   logic             pc_load;
   logic [1:0]       pc_src;
   logic             reg_write;
   logic             alu_src;
   logic             wb_sel;
   logic             halted;
   logic             bus_err;
   logic             trap;
   logic [2:0]       state;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  opcode, branch_taken, mem_ack,
      output mem_req, mem_we, mem_sel_data, ir_load, pc_load, pc_src,
             reg_write, alu_src, wb_sel, halted, bus_err, trap, state,
             instr_count
   );

   modport slave (
      output opcode, branch_taken, mem_ack,
      input  mem_req, mem_we, mem_sel_data, ir_load, pc_load, pc_src,
             reg_write, alu_src, wb_sel, halted, bus_err, trap, state,
             instr_count
   );

endinterface : cpu_seq_ctrl_if

// File: rtl/cpu_opclass.sv
// Combinational opcode-to-class decoder; exactly one is_* output is high
// for any opcode value.
module cpu_opclass
   import cpu_ctrl_pkg::*;
#(
   parameter int OPC_W = 7
) (
   input  logic [OPC_W-1:0] opcode,
   output logic             is_r,
   output logic             is_i,
   output logic             is_load,
   output logic             is_store,
   output logic             is_branch,
   output logic             is_jal,
   output logic             is_halt,
   output logic             is_illegal
);

   // NOTE: every output gets a default before the case, so no path through
   // this block leaves a signal unassigned and no latch is inferred.
   always_comb begin
      is_r       = 1'b0;
      is_i       = 1'b0;
      is_load    = 1'b0;
      is_store   = 1'b0;
      is_branch  = 1'b0;
      is_jal     = 1'b0;
      is_halt    = 1'b0;
      is_illegal = 1'b0;
      case (opcode)
         OPC_W'(OPC_R):      is_r       = 1'b1;
         OPC_W'(OPC_I):      is_i       = 1'b1;
         OPC_W'(OPC_LOAD):   is_load    = 1'b1;
         OPC_W'(OPC_STORE):  is_store   = 1'b1;
         OPC_W'(OPC_BRANCH): is_branch  = 1'b1;
         OPC_W'(OPC_JAL):    is_jal     = 1'b1;
         OPC_W'(OPC_HALT):   is_halt    = 1'b1;
         default:            is_illegal = 1'b1;
      endcase
   end

endmodule : cpu_opclass

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with a shared memory port.
// Optional build macro CPU_ILLEGAL_TRAP_EN: illegal opcodes halt with trap.
module cpu_seq_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int OPC_W       = 7,
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            reset,
   cpu_seq_ctrl_if.master  bus
);

   localparam int WAIT_W = wait_cnt_width(MEM_TIMEOUT);

   state_e             state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               halted_q;
   logic               bus_err_q;

   logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_halt, is_illegal;
   logic uses_imm;
   logic wait_expired;
   logic retire;
   logic timeout_hit;

   logic    mem_req, mem_we, mem_sel_data, ir_load, pc_load;
   logic    reg_write, alu_src, wb_sel;
   pc_src_e pc_src;

`ifdef CPU_ILLEGAL_TRAP_EN
   logic trap_q;
   logic trap_hit;
`endif

   cpu_opclass #(.OPC_W(OPC_W)) u_opclass (
      .opcode     (bus.opcode),
      .is_r       (is_r),
      .is_i       (is_i),
      .is_load    (is_load),
      .is_store   (is_store),
      .is_branch  (is_branch),
      .is_jal     (is_jal),
      .is_halt    (is_halt),
      .is_illegal (is_illegal)
   );

   assign uses_imm     = is_i | is_load | is_store;
   // A timeout of zero never expires; otherwise the current unacked cycle is
   // the MEM_TIMEOUT-th one when the counter already holds MEM_TIMEOUT-1.
   assign wait_expired = (MEM_TIMEOUT != 0) && (int'(wait_q) == MEM_TIMEOUT - 1);

   always_comb begin
      state_d      = state_q;
      wait_d       = '0;
      retire       = 1'b0;
      timeout_hit  = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_sel_data = 1'b0;
      ir_load      = 1'b0;
      pc_load      = 1'b0;
      pc_src       = PC_SRC_SEQ;
      reg_write    = 1'b0;
      alu_src      = 1'b0;
      wb_sel       = 1'b0;
`ifdef CPU_ILLEGAL_TRAP_EN
      trap_hit     = 1'b0;
`endif

      case (state_q)
         ST_RST: state_d = ST_FETCH;

         ST_FETCH: begin
            mem_req = 1'b1;
            if (bus.mem_ack) begin
               ir_load = 1'b1;
               state_d = ST_DECODE;
            end else if (wait_expired) begin
               timeout_hit = 1'b1;
               state_d     = ST_HLT;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end

         ST_DECODE: state_d = ST_EXEC;

         ST_EXEC: begin
            alu_src = uses_imm;
            if (is_load || is_store) begin
               state_d = ST_MEM;
            end else if (is_r || is_i || is_jal) begin
               state_d = ST_WB;
            end else if (is_branch) begin
               pc_load = 1'b1;
               pc_src  = bus.branch_taken ? PC_SRC_BRANCH : PC_SRC_SEQ;
               retire  = 1'b1;
               state_d = ST_FETCH;
            end else if (is_halt) begin
               state_d = ST_HLT;
            end else if (is_illegal) begin
`ifdef CPU_ILLEGAL_TRAP_EN
               trap_hit = 1'b1;
               state_d  = ST_HLT;
`else
               // Treated as a NOP: fall through to the next sequential PC.
               pc_load = 1'b1;
               retire  = 1'b1;
               state_d = ST_FETCH;
`endif
            end
         end

         ST_MEM: begin
            mem_req      = 1'b1;
            mem_sel_data = 1'b1;
            mem_we       = is_store;
            alu_src      = uses_imm;
            if (bus.mem_ack) begin
               if (is_store) begin
                  pc_load = 1'b1;
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end else if (wait_expired) begin
               timeout_hit = 1'b1;
               state_d     = ST_HLT;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end

         ST_WB: begin
            reg_write = 1'b1;
            wb_sel    = is_load;
            alu_src   = uses_imm;
            pc_load   = 1'b1;
            pc_src    = is_jal ? PC_SRC_JUMP : PC_SRC_SEQ;
            retire    = 1'b1;
            state_d   = ST_FETCH;
         end

         ST_HLT: state_d = ST_HLT;

         default: state_d = ST_RST;
      endcase
   end

   // NOTE: the asynchronous reset clears every flop here, including the wait
   // counter, so an abandoned request cannot carry its wait count forward.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_RST;
         wait_q    <= '0;
         cnt_q     <= '0;
         halted_q  <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q <= state_d;
         wait_q  <= wait_d;
         if (retire)
            cnt_q <= cnt_q + 1'b1;
         if (state_d == ST_HLT)
            halted_q <= 1'b1;
         if (timeout_hit)
            bus_err_q <= 1'b1;
      end
   end

`ifdef CPU_ILLEGAL_TRAP_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         trap_q <= 1'b0;
      else if (trap_hit)
         trap_q <= 1'b1;
   end

   assign bus.trap = trap_q;
`else
   assign bus.trap = 1'b0;
`endif

   assign bus.mem_req      = mem_req;
   assign bus.mem_we       = mem_we;
   assign bus.mem_sel_data = mem_sel_data;
   assign bus.ir_load      = ir_load;
   assign bus.pc_load      = pc_load;
   assign bus.pc_src       = pc_src;
   assign bus.reg_write    = reg_write;
   assign bus.alu_src      = alu_src;
   assign bus.wb_sel       = wb_sel;
   assign bus.halted       = halted_q;
   assign bus.bus_err      = bus_err_q;
   assign bus.state        = state_q;
   assign bus.instr_count  = cnt_q;

endmodule : cpu_seq_ctrl

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: instruction-level expected traces are
// expanded into per-cycle expectations and compared on every falling edge.
module tb_cpu_seq_ctrl;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_HALT   = 7'b1111111;
   localparam logic [6:0] OP_BAD    = 7'b0000000;
   localparam logic [6:0] OP_JUNK   = 7'h55;

   typedef struct {
      logic        rst;
      logic        ack;
      logic        taken;
      logic [6:0]  opc;
      logic [2:0]  st;
      logic        req, we, sel, irl, pcl;
      logic [1:0]  pcs;
      logic        rw, alus, wbs;
      logic        hlt, berr, trp;
      logic [31:0] cnt;
      int          pin_cnt;
   } cyc_t;

   logic clk = 1'b0;
   logic reset;

   cpu_seq_ctrl_if #(.OPC_W(7), .CNT_W(32)) bus ();

   cpu_seq_ctrl #(.OPC_W(7), .CNT_W(32), .MEM_TIMEOUT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   cyc_t q[$];
   cyc_t cur;
   bit   chk_en = 1'b0;

   logic [31:0] m_count;
   logic        m_halted, m_berr, m_trap;
   int          next_pin = -1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic cyc_t blank(input logic [2:0] st, input logic [6:0] opc);
      cyc_t r;
      r.rst = 1'b0; r.ack = 1'b0; r.taken = 1'b0; r.opc = opc; r.st = st;
      r.req = 1'b0; r.we = 1'b0; r.sel = 1'b0; r.irl = 1'b0; r.pcl = 1'b0;
      r.pcs = 2'b00; r.rw = 1'b0; r.alus = 1'b0; r.wbs = 1'b0;
      r.hlt = 1'b0; r.berr = 1'b0; r.trp = 1'b0; r.cnt = '0; r.pin_cnt = -1;
      return r;
   endfunction

   // Registered outputs in a record are the values held during that cycle.
   task automatic add(input cyc_t r);
      r.hlt     = m_halted;
      r.berr    = m_berr;
      r.trp     = m_trap;
      r.cnt     = m_count;
      r.pin_cnt = next_pin;
      next_pin  = -1;
      q.push_back(r);
   endtask

   task automatic do_reset(input int n);
      cyc_t r;
      m_count = '0; m_halted = 1'b0; m_berr = 1'b0; m_trap = 1'b0;
      for (int k = 0; k < n; k++) begin
         r = blank(3'd0, OP_R); r.rst = 1'b1; r.ack = 1'b1; add(r);
      end
      r = blank(3'd0, OP_R); r.ack = 1'b1; add(r);
   endtask

   task automatic fetch(input int wf);
      cyc_t r;
      for (int k = 0; k <= wf; k++) begin
         r = blank(3'd1, OP_JUNK); r.req = 1'b1;
         r.ack = (k == wf); r.irl = r.ack; add(r);
      end
   endtask

   task automatic hlt_cycles(input int n);
      cyc_t r;
      for (int k = 0; k < n; k++) begin
         r = blank(3'd6, OP_R); r.ack = 1'b1; add(r);
      end
   endtask

   // One full instruction as seen from outside: fetch, decode, execute and
   // whatever memory / write-back phases its class requires.
   task automatic instr(input logic [6:0] opc, input logic taken, input int wf, input int wm);
      cyc_t r;
      bit is_l, is_s, is_b, is_j, is_h, imm, legal;
      is_l  = (opc == OP_LOAD);
      is_s  = (opc == OP_STORE);
      is_b  = (opc == OP_BRANCH);
      is_j  = (opc == OP_JAL);
      is_h  = (opc == OP_HALT);
      imm   = (opc == OP_I) || is_l || is_s;
      legal = (opc == OP_R) || (opc == OP_I) || is_l || is_s || is_b || is_j || is_h;
      fetch(wf);
      r = blank(3'd2, opc); add(r);
      r = blank(3'd3, opc); r.alus = imm; r.taken = taken;
      if (is_b) begin
         r.pcl = 1'b1; r.pcs = taken ? 2'b01 : 2'b00; add(r); m_count++;
      end else if (is_h) begin
         add(r); m_halted = 1'b1;
      end else if (!legal) begin
`ifdef CPU_ILLEGAL_TRAP_EN
         add(r); m_halted = 1'b1; m_trap = 1'b1;
`else
         r.pcl = 1'b1; add(r); m_count++;
`endif
      end else begin
         add(r);
         if (is_l || is_s) begin
            for (int k = 0; k <= wm; k++) begin
               r = blank(3'd4, opc); r.req = 1'b1; r.sel = 1'b1; r.we = is_s;
               r.alus = 1'b1; r.ack = (k == wm); r.pcl = r.ack && is_s;
               add(r);
               if (r.ack && is_s) m_count++;
            end
         end
         if (!is_s) begin
            r = blank(3'd5, opc); r.rw = 1'b1; r.wbs = is_l; r.pcl = 1'b1;
            r.pcs = is_j ? 2'b10 : 2'b00; r.alus = imm; add(r); m_count++;
         end
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("state",        64'(bus.state),        64'(cur.st));
         check("mem_req",      64'(bus.mem_req),      64'(cur.req));
         check("mem_we",       64'(bus.mem_we),       64'(cur.we));
         check("mem_sel_data", 64'(bus.mem_sel_data), 64'(cur.sel));
         check("ir_load",      64'(bus.ir_load),      64'(cur.irl));
         check("pc_load",      64'(bus.pc_load),      64'(cur.pcl));
         check("pc_src",       64'(bus.pc_src),       64'(cur.pcs));
         check("reg_write",    64'(bus.reg_write),    64'(cur.rw));
         check("alu_src",      64'(bus.alu_src),      64'(cur.alus));
         check("wb_sel",       64'(bus.wb_sel),       64'(cur.wbs));
         check("halted",       64'(bus.halted),       64'(cur.hlt));
         check("bus_err",      64'(bus.bus_err),      64'(cur.berr));
         check("trap",         64'(bus.trap),         64'(cur.trp));
         check("instr_count",  64'(bus.instr_count),  64'(cur.cnt));
         if (cur.pin_cnt >= 0)
            check("pin_instr_count", 64'(bus.instr_count), 64'(cur.pin_cnt));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish within time limit");
      $fatal(1);
   end

   initial begin
      int n0;
      reset            = 1'b1;
      bus.mem_ack      = 1'b0;
      bus.opcode       = OP_JUNK;
      bus.branch_taken = 1'b0;
      m_count = '0; m_halted = 1'b0; m_berr = 1'b0; m_trap = 1'b0;

      do_reset(3);

      n0 = q.size(); instr(OP_R, 1'b0, 0, 0);
      check("lat_r", 64'(q.size() - n0), 64'd4);
      next_pin = 1;
      n0 = q.size(); instr(OP_I, 1'b0, 1, 0);
      check("lat_i_wait1", 64'(q.size() - n0), 64'd5);
      next_pin = 2;
      n0 = q.size(); instr(OP_JAL, 1'b0, 0, 0);
      check("lat_jal", 64'(q.size() - n0), 64'd4);
      n0 = q.size(); instr(OP_LOAD, 1'b0, 0, 2);
      check("lat_load_wait2", 64'(q.size() - n0), 64'd7);
      next_pin = 4;
      n0 = q.size(); instr(OP_STORE, 1'b0, 0, 1);
      check("lat_store_wait1", 64'(q.size() - n0), 64'd5);
      n0 = q.size(); instr(OP_BRANCH, 1'b1, 0, 0);
      check("lat_branch_t", 64'(q.size() - n0), 64'd3);
      n0 = q.size(); instr(OP_BRANCH, 1'b0, 0, 0);
      check("lat_branch_nt", 64'(q.size() - n0), 64'd3);
      next_pin = 7;
      instr(OP_BAD, 1'b0, 0, 0);
`ifdef CPU_ILLEGAL_TRAP_EN
      next_pin = 7;
      hlt_cycles(2);
      do_reset(2);
      instr(OP_R, 1'b0, 0, 0);
      next_pin = 1;
`else
      next_pin = 8;
`endif

      // Store abandoned by reset while waiting in MEM.
      fetch(0);
      begin
         cyc_t r;
         r = blank(3'd2, OP_STORE); add(r);
         r = blank(3'd3, OP_STORE); r.alus = 1'b1; add(r);
         r = blank(3'd4, OP_STORE); r.req = 1'b1; r.sel = 1'b1; r.we = 1'b1;
         r.alus = 1'b1; add(r);
      end
      do_reset(2);
      q[q.size() - 3].pin_cnt = 0;

      // Fetch never acknowledged: timeout after four request cycles.
      next_pin = 0;
      begin
         cyc_t r;
         for (int k = 0; k < 4; k++) begin
            r = blank(3'd1, OP_JUNK); r.req = 1'b1; add(r);
         end
      end
      m_halted = 1'b1; m_berr = 1'b1;
      hlt_cycles(3);

      do_reset(2);
      instr(OP_R, 1'b0, 0, 0);
      next_pin = 1;
      n0 = q.size(); instr(OP_HALT, 1'b0, 0, 0);
      check("lat_halt", 64'(q.size() - n0), 64'd3);
      next_pin = 1;
      hlt_cycles(3);

      foreach (q[i]) begin
         @(posedge clk);
         #1;
         reset            = q[i].rst;
         bus.mem_ack      = q[i].ack;
         bus.opcode       = q[i].opc;
         bus.branch_taken = q[i].taken;
         cur              = q[i];
         chk_en           = 1'b1;
      end
      @(posedge clk);
      #1;
      chk_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_cpu_seq_ctrl
